// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one MMU data port between instruction fetch (I) and
// the memory stage (D). Define ARB_RR_EN to add I-port starvation relief.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_ready,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_valid,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [3:0]       d_byte_en,
    output logic             d_ready,
    output logic [WIDTH-1:0] d_rdata,
    output logic             mem_valid,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_w_data,
    output logic [3:0]       mem_byte_en,
    input  logic [WIDTH-1:0] mem_r_data,
    input  logic             mem_ready,
    output logic             busy_d
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state;
    logic   grant_d;
    logic   grant_i;

`ifdef ARB_RR_EN
    logic [3:0] starve_cnt;
    logic       i_forced;

    // Once D has won STARVE_MAX times in a row with I waiting, I takes the next slot.
    assign i_forced = i_valid && (int'(starve_cnt) >= STARVE_MAX);
    assign grant_d  = d_valid && !i_forced;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d && i_valid && starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
            else if (grant_i)
                starve_cnt <= '0;
        end
    end
`else
    assign grant_d = d_valid;
`endif

    assign grant_i = i_valid && !grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_w_data  <= '0;
            mem_byte_en <= '0;
            busy_d      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        mem_valid   <= 1'b1;
                        mem_we      <= d_we;
                        mem_addr    <= d_addr;
                        mem_w_data  <= d_wdata;
                        mem_byte_en <= d_byte_en;
                        busy_d      <= 1'b1;
                    end else if (grant_i) begin
                        state       <= SERVE_I;
                        mem_valid   <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= i_addr;
                        mem_w_data  <= '0;
                        mem_byte_en <= '0;
                        busy_d      <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Request fields stay frozen until the MMU completes.
                    if (mem_ready) begin
                        state       <= IDLE;
                        mem_valid   <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_w_data  <= '0;
                        mem_byte_en <= '0;
                        busy_d      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is routed back in the same cycle the MMU reports it.
    assign i_ready = (state == SERVE_I) && mem_ready;
    assign d_ready = (state == SERVE_D) && mem_ready;
    assign i_rdata = i_ready ? mem_r_data : '0;
    assign d_rdata = d_ready ? mem_r_data : '0;

endmodule
